// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM with trap detection and retired-instruction counter
module multicycle_controller #(
  parameter int XLEN          = 32,
  parameter int CNT_W         = 32,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic [XLEN-1:0]  RF_OUT1,
  input  logic [XLEN-1:0]  RF_OUT2,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             AdrSrc,
  output logic             PCSel,
  output logic [1:0]       MemWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       READMODE,
  output logic [3:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t            state_q, state_d, dec_next;
  logic              run_q, illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3, imm_sel;
  logic [3:0] alu_op;
  logic [1:0] st_size;
  logic       mem_ok, f7_std, f7_alt, shift_i, bad_fields, br_taken;
  logic       unused_instr;

  assign opcode       = Instr[6:0];
  assign funct3       = Instr[14:12];
  assign funct7       = Instr[31:25];
  assign unused_instr = ^{Instr[24:15], Instr[11:7]};
  assign mem_ok       = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

  assign f7_std  = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);
  assign shift_i = (funct3[1:0] == 2'b01);
  assign st_size = funct3[1:0] + 2'd1;

  // Field-level encodings that reuse a legal opcode but have no defined meaning.
  assign bad_fields =
      (opcode == OP_STORE  && funct3 > 3'b010) ||
      (opcode == OP_LOAD   && (funct3 == 3'b011 || funct3[2:1] == 2'b11)) ||
      (opcode == OP_BRANCH && funct3[2:1] == 2'b01) ||
      (opcode == OP_R && (!(f7_std || f7_alt) ||
                          (f7_alt && funct3 != 3'b000 && funct3 != 3'b101))) ||
      (opcode == OP_I && shift_i && (!(f7_std || f7_alt) ||
                                     (f7_alt && funct3 != 3'b101)));

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LUI, OP_AUIPC: dec_next = S_EXEC;
      OP_LOAD, OP_STORE:            dec_next = S_MEMADR;
      OP_BRANCH:                    dec_next = S_BRANCH;
      OP_JAL, OP_JALR:              dec_next = S_JUMP;
      default:                      dec_next = S_TRAP;
    endcase
    if (bad_fields) dec_next = S_TRAP;
  end

  always_comb begin
    imm_sel = 3'b000;
    case (opcode)
      OP_I:             if (funct3 == 3'b011) imm_sel = 3'b001;
      OP_BRANCH:        imm_sel = 3'b010;
      OP_JAL:           imm_sel = 3'b011;
      OP_LUI, OP_AUIPC: imm_sel = 3'b100;
      default:          imm_sel = 3'b000;
    endcase
  end

  always_comb begin
    alu_op = 4'b0000;
    if (opcode == OP_R || (opcode == OP_I && shift_i)) alu_op = {funct3, funct7[5]};
    else if (opcode == OP_I)                           alu_op = {funct3, 1'b0};
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (RF_OUT1 == RF_OUT2);
      3'b001:  br_taken = (RF_OUT1 != RF_OUT2);
      3'b100:  br_taken = ($signed(RF_OUT1) <  $signed(RF_OUT2));
      3'b101:  br_taken = ($signed(RF_OUT1) >= $signed(RF_OUT2));
      3'b110:  br_taken = (RF_OUT1 <  RF_OUT2);
      3'b111:  br_taken = (RF_OUT1 >= RF_OUT2);
      default: br_taken = 1'b0;
    endcase
  end

  // run_q keeps every strobe low until the first edge after reset releases.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    AdrSrc     = 1'b0;
    PCSel      = 1'b0;
    MemWrite   = 2'b00;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 3'b000;
    READMODE   = 3'b000;
    ALUControl = 4'b0000;
    state_d    = state_q;
    illegal_d  = illegal_q;
    if (run_q) begin
      if (state_q != S_FETCH && state_q != S_TRAP) ImmSrc = imm_sel;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          if (mem_ok) begin
            IRWrite = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          state_d   = dec_next;
          illegal_d = illegal_q | (dec_next == S_TRAP);
        end
        S_EXEC: begin
          RegWrite   = 1'b1;
          PCWrite    = 1'b1;
          ALUControl = alu_op;
          case (opcode)
            OP_R:     begin ALUSrcA = 2'b01; ALUSrcB = 2'b00; end
            OP_LUI:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            OP_AUIPC: begin ALUSrcA = 2'b00; ALUSrcB = 2'b01; end
            default:  begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
          endcase
          state_d = S_FETCH;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemRead  = 1'b1;
          AdrSrc   = 1'b1;
          READMODE = funct3;
          if (mem_ok) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite  = 1'b1;
          ResultSrc = 2'b01;
          PCWrite   = 1'b1;
          state_d   = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = st_size;
          AdrSrc   = 1'b1;
          if (mem_ok) begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_BRANCH: begin
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
          PCSel   = br_taken;
          state_d = S_FETCH;
        end
        S_JUMP: begin
          ALUSrcA   = (opcode == OP_JALR) ? 2'b01 : 2'b00;
          ALUSrcB   = 2'b01;
          RegWrite  = 1'b1;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
          PCSel     = 1'b1;
          state_d   = S_FETCH;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign retired_d = retired_q + CNT_W'(PCWrite);
  assign retired   = retired_q;
  assign illegal   = illegal_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized bench for multicycle_controller against a per-instruction trace model
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr, RF_OUT1, RF_OUT2;
  logic        mem_ready;
  logic        PCWrite, IRWrite, RegWrite, MemRead, AdrSrc, PCSel, illegal;
  logic [1:0]  MemWrite, ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc, READMODE;
  logic [3:0]  ALUControl;
  logic [3:0]  retired;

  multicycle_controller #(.XLEN(32), .CNT_W(4), .MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .RF_OUT1(RF_OUT1), .RF_OUT2(RF_OUT2),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .AdrSrc(AdrSrc), .PCSel(PCSel), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .READMODE(READMODE), .ALUControl(ALUControl), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, irw, rw, mr, adr, pcsel;
    logic [1:0] mw, rs, sa, sb;
    logic [2:0] imm, rm;
    logic [3:0] alu;
    logic ill;
  } ctl_t;

  ctl_t dut_ctl;
  assign dut_ctl = {PCWrite, IRWrite, RegWrite, MemRead, AdrSrc, PCSel, MemWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ImmSrc, READMODE, ALUControl, illegal};

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_model = 0;
  int instr_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  ctl_t exp_q[$];
  bit   rdy_q[$];
  bit   ir_q[$];

  task automatic push(input ctl_t c, input bit rdy, input bit ir);
    exp_q.push_back(c);
    rdy_q.push_back(rdy);
    ir_q.push_back(ir);
  endtask

  function automatic bit legal(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    case (op)
      7'h33: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      7'h13: begin
        if (f3 == 3'd1) return f7 == 7'h00;
        if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
        return 1'b1;
      end
      7'h37, 7'h17, 7'h6f, 7'h67: return 1'b1;
      7'h03: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      7'h23: return f3 <= 3'd2;
      7'h63: return !(f3 inside {3'd2, 3'd3});
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h13:        return (ins[14:12] == 3'd3) ? 3'd1 : 3'd0;
      7'h63:        return 3'd2;
      7'h6f:        return 3'd3;
      7'h37, 7'h17: return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic bit taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Builds the expected per-cycle control trace of one instruction, then plays it against the DUT.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic [31:0] a, input logic [31:0] b,
                           input int abort_at, output bit trapped);
    ctl_t c;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [2:0] im = imm_of(ins);
    exp_q.delete(); rdy_q.delete(); ir_q.delete();
    instr_no++;
    for (int i = 0; i < fw; i++) begin c = '0; c.mr = 1; push(c, 0, 0); end
    c = '0; c.mr = 1; c.irw = 1; push(c, 1, 0);
    c = '0; c.imm = im; push(c, 1'($urandom), 1);
    trapped = !legal(ins);
    if (trapped) begin
      for (int i = 0; i < 3; i++) begin c = '0; c.ill = 1; push(c, 1'($urandom), 1); end
    end else begin
      c = '0; c.imm = im;
      case (op)
        7'h03, 7'h23: begin
          c.sa = 1; c.sb = 1; push(c, 1'($urandom), 1);
          c = '0; c.imm = im; c.adr = 1;
          if (op == 7'h03) begin c.mr = 1; c.rm = f3; end
          else c.mw = 2'(f3[1:0] + 2'd1);
          for (int i = 0; i < mw; i++) push(c, 0, 1);
          if (op == 7'h23) c.pcw = 1;
          push(c, 1, 1);
          if (op == 7'h03) begin
            c = '0; c.imm = im; c.rw = 1; c.rs = 1; c.pcw = 1; push(c, 1'($urandom), 1);
          end
        end
        7'h63: begin
          c.sb = 1; c.pcw = 1; c.pcsel = taken(f3, a, b); push(c, 1'($urandom), 1);
        end
        7'h6f, 7'h67: begin
          c.sa = (op == 7'h67) ? 2'd1 : 2'd0; c.sb = 1; c.rw = 1; c.rs = 2;
          c.pcw = 1; c.pcsel = 1; push(c, 1'($urandom), 1);
        end
        default: begin
          c.rw = 1; c.pcw = 1;
          case (op)
            7'h33: begin c.sa = 1; c.sb = 0; c.alu = {f3, ins[30]}; end
            7'h13: begin
              c.sa = 1; c.sb = 1;
              c.alu = (f3 == 3'd1 || f3 == 3'd5) ? {f3, ins[30]} : {f3, 1'b0};
            end
            7'h37: begin c.sa = 2; c.sb = 1; end
            default: begin c.sa = 0; c.sb = 1; end
          endcase
          push(c, 1'($urandom), 1);
        end
      endcase
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      Instr = ir_q[i] ? ins : $urandom;
      mem_ready = rdy_q[i];
      RF_OUT1 = a;
      RF_OUT2 = b;
      #1;
      if (i == 0) check($sformatf("retired#%0d", instr_no), 32'(retired), cnt_model);
      check($sformatf("ctl#%0d.%0d", instr_no, i), 32'(dut_ctl), 32'(exp_q[i]));
      if (i == abort_at) begin
        #2 reset = 1'b0;
        #1;
        check("abort_ctl", 32'(dut_ctl), 32'd0);
        check("abort_memwrite", 32'(MemWrite), 32'd0);
        check("abort_retired", 32'(retired), 32'd0);
        break;
      end
    end
    if (!trapped && abort_at < 0) cnt_model = (cnt_model + 1) % 16;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ctl", 32'(dut_ctl), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    #1;
    check("rst_hold_ctl", 32'(dut_ctl), 32'd0);
    reset = 1'b1;
    cnt_model = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] r = $urandom;
    int sel = $urandom_range(0, 19);
    int k = $urandom_range(0, 9);
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67};
    r[6:0] = (sel < 18) ? ops[sel % 9] : 7'($urandom);
    if (k < 7) r[31:25] = 7'h00;
    else if (k < 9) r[31:25] = 7'h20;
    return r;
  endfunction

  initial begin
    bit t;
    logic [31:0] a, b;
    reset = 1'b0; Instr = '0; RF_OUT1 = '0; RF_OUT2 = '0; mem_ready = 1'b0;
    do_reset();

    run_instr(32'h002081B3, 0, 0, 32'd5, 32'd7, -1, t);          // ADD x3,x1,x2
    run_instr(32'h0000A283, 0, 2, 32'd0, 32'd0, -1, t);          // LW, 2 wait cycles
    run_instr(32'h00208023, 1, 1, 32'd0, 32'd0, -1, t);          // SB
    run_instr(32'h00209023, 0, 0, 32'd0, 32'd0, -1, t);          // SH
    run_instr(32'h0020E063, 0, 0, 32'd1, 32'hFFFFFFFF, -1, t);   // BLTU taken
    run_instr(32'h0020C063, 0, 0, 32'd1, 32'hFFFFFFFF, -1, t);   // BLT not taken
    run_instr(32'h000100E7, 0, 0, 32'd0, 32'd0, -1, t);          // JALR
    run_instr(32'h008000EF, 0, 0, 32'd0, 32'd0, -1, t);          // JAL
    run_instr(32'h123452B7, 0, 0, 32'd0, 32'd0, -1, t);          // LUI
    run_instr(32'h00001297, 0, 0, 32'd0, 32'd0, -1, t);          // AUIPC
    run_instr(32'h4030D293, 0, 0, 32'd0, 32'd0, -1, t);          // SRAI
    run_instr(32'h402081B3, 0, 0, 32'd0, 32'd0, -1, t);          // SUB
    run_instr(32'h0020B023, 0, 0, 32'd0, 32'd0, -1, t);          // store funct3=011
    check("sd_traps", 32'(t), 32'd1);
    do_reset();

    run_instr(32'h002081B3, 0, 0, 32'd0, 32'd0, -1, t);
    run_instr(32'h0020A023, 0, 3, 32'd0, 32'd0, 3, t);           // SW aborted by reset in MEMWR
    @(negedge clk);
    reset = 1'b1;
    cnt_model = 0;

    for (int i = 0; i < 17; i++) run_instr(32'h002081B3, 0, 0, 32'd0, 32'd0, -1, t);
    @(posedge clk);
    #1;
    check("wrap17", 32'(retired), 32'd1);

    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 32'h80000000;
        default: b = $urandom;
      endcase
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), a, b, -1, t);
      if (t) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, register-file operand width.
REQ-002 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 SHALL have parameter MEM_HANDSHAKE, default 1; when 0, mem_ready is ignored and treated as 1.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 Instr  in  32  instruction register contents, valid from DECODE onward.
REQ-007 RF_OUT1, RF_OUT2  in  XLEN  register operands for branch compare.
REQ-008 mem_ready  in  1  memory completes the current read/write this cycle.
REQ-009 PCWrite, IRWrite, RegWrite, MemRead, AdrSrc, PCSel  out  1 each  strobes; AdrSrc 0=PC, 1=held ALU result; PCSel 0=PC+4, 1=ALU result.
REQ-010 MemWrite  out  2  00 none, 01 byte, 10 half, 11 word.
REQ-011 ResultSrc  out  2  00 ALU, 01 memory, 10 PC+4.
REQ-012 ALUSrcA  out  2  00 PC, 01 RF_OUT1, 10 zero; ALUSrcB  out  2  00 RF_OUT2, 01 immediate, 10 constant 4.
REQ-013 ImmSrc  out  3, READMODE  out  3, ALUControl  out  4  same encodings as the single-cycle controller.
REQ-014 illegal  out  1  sticky trap flag; retired  out  CNT_W  count of completed instructions.

Function
REQ-015 SHALL implement states FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, TRAP.
REQ-016 FETCH: MemRead=1, AdrSrc=0; on mem_ready, IRWrite=1 and next state DECODE; otherwise hold FETCH.
REQ-017 DECODE: R/I-ALU, LUI, AUIPC -> EXEC; load/store -> MEMADR; branch -> BRANCH; JAL/JALR -> JUMP; any other opcode -> TRAP.
REQ-018 DECODE SHALL also route to TRAP on: store funct3 > 010; load funct3 of 011, 110 or 111; branch funct3 of 010 or 011; shift or R-type funct7 other than 0000000/0100000; funct7=0100000 on a funct3 other than 000 (R-type) or 101.
REQ-019 EXEC: RegWrite=1, ResultSrc=00, PCWrite=1, PCSel=0, next FETCH.
REQ-019a EXEC operand select: R-type A=01, B=00; I-type A=01, B=01; LUI A=10, B=01; AUIPC A=00, B=01.
REQ-020 ALUControl SHALL be {funct3, funct7[5]} for R-type, SRLI/SRAI and SLLI; {funct3, 0} for other I-type; 0000 (ADD) for all other states.
REQ-021 MEMADR: A=01, B=01, ADD; next MEMRD for load, MEMWR for store; datapath latches ALU result.
REQ-022 MEMRD: MemRead=1, AdrSrc=1, READMODE=funct3; on mem_ready -> MEMWB, else hold.
REQ-023 MEMWB: RegWrite=1, ResultSrc=01, PCWrite=1, PCSel=0, next FETCH.
REQ-024 MEMWR: MemWrite=size code, AdrSrc=1; on mem_ready PCWrite=1, PCSel=0 -> FETCH, else hold.
REQ-025 BRANCH: A=00, B=01, ADD; internal compare per funct3 (EQ, NE, signed LT/GE, unsigned LTU/GEU over XLEN bits); PCWrite=1, PCSel=taken; next FETCH.
REQ-026 JUMP: A=00 (JAL) or 01 (JALR), B=01, ADD; RegWrite=1, ResultSrc=10, PCWrite=1, PCSel=1; next FETCH.
REQ-026a JALR bit-0 clearing is done in the datapath.
REQ-027 ImmSrc SHALL be 001 for SLTIU, 010 for branch, 011 for JAL, 100 for LUI/AUIPC, 000 otherwise.
REQ-028 TRAP: illegal=1, all write strobes 0, PCWrite=0; remains in TRAP until reset.
REQ-029 Latency at mem_ready=1: ALU/LUI/AUIPC/branch/jump 3 cycles, store 4, load 5; each mem_ready-low cycle adds one.
REQ-030 While waiting on mem_ready, every output SHALL hold constant.
REQ-031 retired SHALL increment by 1 on each cycle with PCWrite=1 and wrap from 2^CNT_W-1 to 0.

Reset
REQ-032 While reset=0, state SHALL be FETCH, illegal=0, retired=0, and all outputs 0.
REQ-033 Reset asserted mid-instruction SHALL abort it with no further write strobes.
REQ-034 First FETCH cycle SHALL be the first clk edge after reset deasserts.

Verification
REQ-035 ADD x3,x1,x2 with mem_ready=1 -> FETCH, DECODE, EXEC; RegWrite=1 in cycle 3 only; ALUControl=0000; retired 0->1.
REQ-036 LW, mem_ready low 2 cycles in MEMRD -> 7 cycles total; READMODE=010; RegWrite only in MEMWB.
REQ-037 SB -> MemWrite=01 for exactly one accepted cycle; SH -> 10; store funct3=011 -> TRAP, illegal=1, no MemWrite.
REQ-038 BLTU, RF_OUT1=1, RF_OUT2=0xFFFFFFFF -> PCSel=1; BLT with same operands -> PCSel=0.
REQ-039 JALR -> ResultSrc=10, ALUSrcA=01, PCSel=1, RegWrite=1 in cycle 3.
REQ-040 Reset asserted in MEMWR -> MemWrite=0 immediately; CNT_W=4 run of 17 instructions -> retired=1.
